// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: data width, fetch FSM encoding and the bubble
// instruction that decode also recognises.
package rv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t;

    // Instruction addresses are word aligned; low bits of a target are dropped.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: kill beats load, load beats hold, and an unstalled
// cycle with nothing to load becomes a bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_instr,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic [31:0] instr_d,
    output logic        valid_d
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_d      <= '0;
            pcplus4_d <= '0;
            instr_d   <= NOP_INSTR;
            valid_d   <= 1'b0;
        end else if (kill) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (load) begin
            pc_d      <= ld_pc;
            pcplus4_d <= ld_pc + 32'd4;
            instr_d   <= ld_instr;
            valid_d   <= 1'b1;
        end else if (!stall) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding request FSM, PC update and redirect
// handling, feeding the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic [31:0] instr_d,
    output logic        valid_d
);
    import rv_pipe_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;
    logic         load;
    logic [31:0]  ld_instr;

    // Reset forces the state to REQ, so the request is also gated by reset.
    assign imem_req  = reset && (state == REQ);
    assign imem_addr = pc_q;
    assign pc_f      = pc_q;

    assign load     = !redirect_valid && !stall_f &&
                      (((state == WAIT) && imem_rvalid) || (state == HOLD));
    assign ld_instr = (state == HOLD) ? hold_q : imem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= REQ;
            pc_q   <= RESET_PC;
            hold_q <= '0;
        end else if (redirect_valid) begin
            pc_q   <= pc_align(redirect_pc);
            hold_q <= '0;
            case (state)
                REQ:     state <= imem_gnt ? DROP : REQ;
                WAIT:    state <= imem_rvalid ? REQ : DROP;
                HOLD:    state <= REQ;
                default: state <= DROP;
            endcase
        end else begin
            if (load)
                pc_q <= pc_q + 32'd4;
            case (state)
                REQ:  if (imem_gnt) state <= WAIT;
                WAIT: if (imem_rvalid) begin
                    if (stall_f) begin
                        hold_q <= imem_rdata;
                        state  <= HOLD;
                    end else begin
                        state <= REQ;
                    end
                end
                HOLD: if (!stall_f) state <= REQ;
                default: if (imem_rvalid) state <= REQ;
            endcase
        end
    end

    // Flush and redirect both kill IF/ID; flush alone leaves fetch untouched.
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .kill      (flush_d || redirect_valid),
        .load      (load),
        .stall     (stall_f),
        .ld_pc     (pc_q),
        .ld_instr  (ld_instr),
        .pc_d      (pc_d),
        .pcplus4_d (pcplus4_d),
        .instr_d   (instr_d),
        .valid_d   (valid_d)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of fetch (outstanding / drop / hold queue).
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0, reset = 1'b1;
    logic        stall_f = 0, flush_d = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] pc_f, pc_d, pcplus4_d, instr_d;
    logic        valid_d;

    int checks = 0, errors = 0;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_f(pc_f),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .instr_d(instr_d), .valid_d(valid_d)
    );

    always #5 clk = ~clk;

    // Memory: contents by address, one outstanding access with a countdown.
    logic        mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0, mem_lat = 0;
    bit          rand_lat = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    // Reference model: fetch PC, request in flight, response to discard,
    // words waiting for decode, and the expected IF/ID contents.
    logic [31:0] m_pc;
    bit          m_out, m_drop;
    logic [31:0] m_held[$];
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid;

    function automatic void init_model();
        m_pc = RST_PC; m_out = 0; m_drop = 0; m_held.delete();
        e_pc = '0; e_pc4 = '0; e_instr = NOP; e_valid = 0;
    endfunction

    task automatic cycle(input logic st, input logic fl, input logic rd,
                         input logic [31:0] rpc, input logic g);
        logic rv, rdx, mreq, ld;
        logic [31:0] rq_pc, ldw;
        @(negedge clk);
        rv  = mem_busy && (mem_cnt == 0);
        rdx = rd && !(m_drop && rv);
        stall_f = st; flush_d = fl; redirect_valid = rdx; redirect_pc = rpc;
        imem_gnt = g && !mem_busy; imem_rvalid = rv;
        imem_rdata = rv ? memf(mem_addr) : $urandom();
        #1;
        mreq = !m_out && !m_drop && (m_held.size() == 0);
        checks++;
        if (imem_req !== mreq) begin errors++; $display("FAIL imem_req: got %b want %b", imem_req, mreq); end
        if (mreq) begin
            checks++;
            if (imem_addr !== m_pc) begin errors++; $display("FAIL imem_addr: got %h want %h", imem_addr, m_pc); end
        end
        rq_pc = m_pc; ld = 0; ldw = '0;
        if (rdx) begin
            if (mreq) m_drop = imem_gnt;
            else if (m_out) begin m_out = 0; m_drop = !rv; end
            else if (m_held.size() != 0) m_held.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (mreq) m_out = imem_gnt;
            else if (m_out && rv) begin
                m_out = 0;
                if (st) m_held.push_back(imem_rdata);
                else begin ld = 1; ldw = imem_rdata; end
            end else if (m_held.size() != 0 && !st) begin
                ld = 1; ldw = m_held.pop_front();
            end else if (m_drop && rv) m_drop = 0;
            if (ld) m_pc = m_pc + 32'd4;
        end
        if (rdx || fl) begin e_valid = 0; e_instr = NOP; end
        else if (ld) begin e_valid = 1; e_instr = ldw; e_pc = rq_pc; e_pc4 = rq_pc + 32'd4; end
        else if (!st) begin e_valid = 0; e_instr = NOP; end
        @(posedge clk); #1;
        if (rv) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (mreq && imem_gnt) begin
            mem_busy = 1; mem_addr = rq_pc;
            mem_cnt = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
        end
        checks += 5;
        if (pc_f !== m_pc)         begin errors++; $display("FAIL pc_f: got %h want %h", pc_f, m_pc); end
        if (valid_d !== e_valid)   begin errors++; $display("FAIL valid_d: got %b want %b", valid_d, e_valid); end
        if (instr_d !== e_instr)   begin errors++; $display("FAIL instr_d: got %h want %h", instr_d, e_instr); end
        if (pc_d !== e_pc)         begin errors++; $display("FAIL pc_d: got %h want %h", pc_d, e_pc); end
        if (pcplus4_d !== e_pc4)   begin errors++; $display("FAIL pcplus4_d: got %h want %h", pcplus4_d, e_pc4); end
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #1;
        checks += 5;
        if (pc_f !== RST_PC) begin errors++; $display("FAIL rst_pc_f: got %h want %h", pc_f, RST_PC); end
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL rst_ifid: got %b/%h want 0/%h", valid_d, instr_d, NOP); end
        if (pc_d !== 32'h0) begin errors++; $display("FAIL rst_pc_d: got %h want 0", pc_d); end
        if (pcplus4_d !== 32'h0) begin errors++; $display("FAIL rst_pcplus4_d: got %h want 0", pcplus4_d); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        init_model();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL first_req: got %b@%h want 1@%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        mem_lat = 0;
        repeat (2) cycle(0, 0, 0, '0, 1);
        checks++;
        if ({valid_d, pc_d, pcplus4_d, instr_d} !== {1'b1, 32'h0, 32'h4, 32'h0050_0093}) begin
            errors++; $display("FAIL seq0: got %b %h %h %h", valid_d, pc_d, pcplus4_d, instr_d);
        end
        cycle(0, 0, 0, '0, 1);
        checks++;
        if (valid_d !== 1'b0) begin errors++; $display("FAIL seq_gap: got %b want 0", valid_d); end
        cycle(0, 0, 0, '0, 1);
        checks++;
        if ({valid_d, pc_d, pcplus4_d, instr_d} !== {1'b1, 32'h4, 32'h8, 32'h00A0_0113}) begin
            errors++; $display("FAIL seq1: got %b %h %h %h", valid_d, pc_d, pcplus4_d, instr_d);
        end
    endtask

    task automatic test_stall();
        repeat (3) cycle(1, 0, 0, '0, 1);
        checks++;
        if ({valid_d, pc_d, instr_d} !== {1'b1, 32'h4, 32'h00A0_0113}) begin
            errors++; $display("FAIL stall_hold: got %b %h %h", valid_d, pc_d, instr_d);
        end
        cycle(0, 0, 0, '0, 1);
        checks++;
        if ({valid_d, pc_d, pcplus4_d, instr_d} !== {1'b1, 32'h8, 32'hC, 32'h0020_81B3}) begin
            errors++; $display("FAIL stall_release: got %b %h %h %h", valid_d, pc_d, pcplus4_d, instr_d);
        end
    endtask

    task automatic test_redirect_wait();
        bit seen = 0, req_seen = 0;
        mem_lat = 2;
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 1, 32'h0000_0103, 1);
        checks++;
        if (pc_f !== 32'h100 || valid_d !== 1'b0) begin
            errors++; $display("FAIL redir_pc: got %h/%b want 00000100/0", pc_f, valid_d);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 0, '0, 1);
            if (imem_req && !req_seen) begin
                req_seen = 1; checks++;
                if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", imem_addr); end
            end
            seen = valid_d;
        end
        checks++;
        if (!seen || pc_d !== 32'h100 || instr_d !== memf(32'h100)) begin
            errors++; $display("FAIL redir_fetch: got %b %h %h want 1 00000100 %h", seen, pc_d, instr_d, memf(32'h100));
        end
    endtask

    task automatic test_flush_stall();
        cycle(1, 1, 0, '0, 1);
        checks++;
        if (valid_d !== 1'b0 || instr_d !== 32'h0000_0013) begin
            errors++; $display("FAIL flush_stall: got %b/%h want 0/00000013", valid_d, instr_d);
        end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 0, '0, 1);
            seen = valid_d;
        end
        checks++;
        if (!seen || pc_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0 || pc_f !== 32'h0) begin
            errors++; $display("FAIL wrap: got %b %h %h %h", seen, pc_d, pcplus4_d, pc_f);
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        mem_lat = 2;
        for (int i = 0; i < 10 && !m_out; i++) cycle(0, 0, 0, '0, 1);
        #2 reset = 0;
        #1;
        checks++;
        if ({imem_req, valid_d, pc_f, instr_d, pc_d} !== {1'b0, 1'b0, RST_PC, NOP, 32'h0}) begin
            errors++; $display("FAIL midrst: got %b %b %h %h %h", imem_req, valid_d, pc_f, instr_d, pc_d);
        end
        stall_f = 0; flush_d = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        init_model();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++; $display("FAIL midrst_req: got %b@%h want 1@%h", imem_req, imem_addr, RST_PC);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 0, '0, 1);
            seen = valid_d;
        end
        checks++;
        if (!seen || pc_d !== RST_PC || instr_d !== memf(RST_PC)) begin
            errors++; $display("FAIL midrst_fetch: got %b %h %h", seen, pc_d, instr_d);
        end
    endtask

    task automatic test_random();
        rand_lat = 1;
        repeat (1500)
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 9) < 7);
    endtask

    initial begin
        init_model();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_flush_stall();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
